// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared op codes, FSM states and helpers for the multiply/divide unit
package mdu_pkg;

  localparam logic [2:0] MDU_MULT  = 3'd0;
  localparam logic [2:0] MDU_MULTU = 3'd1;
  localparam logic [2:0] MDU_DIV   = 3'd2;
  localparam logic [2:0] MDU_DIVU  = 3'd3;
  localparam logic [2:0] MDU_MTHI  = 3'd4;
  localparam logic [2:0] MDU_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } mdu_state_e;

  localparam int unsigned MDU_ITERS     = 32;
  localparam logic [4:0]  MDU_LAST_ITER = 5'(MDU_ITERS - 1);

  function automatic logic [31:0] mdu_abs32(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/mdu_iter_core.sv
// rtl/mdu_iter_core.sv - one radix-2 shift-add or restoring trial-subtract step
module mdu_iter_core (
  input  logic        is_div_i,
  input  logic [63:0] acc_i,
  input  logic [31:0] opnd_i,
  output logic [63:0] acc_o
);

  logic [32:0] add_sum;
  logic [32:0] sub_diff;

  // Multiply: acc = {partial product, remaining multiplier bits}
  assign add_sum  = {1'b0, acc_i[63:32]} + {1'b0, (acc_i[0] ? opnd_i : 32'd0)};
  // Divide: acc = {partial remainder, dividend bits / quotient bits}
  assign sub_diff = acc_i[63:31] - {1'b0, opnd_i};

  always_comb begin
    acc_o = {add_sum, acc_i[31:1]};
    if (is_div_i) begin
      if (!sub_diff[32]) begin
        acc_o = {sub_diff[31:0], acc_i[30:0], 1'b1};
      end else begin
        acc_o = {acc_i[62:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative MIPS multiply/divide unit with HI/LO registers
module mul_div_unit
  import mdu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        op_valid,
  input  logic [2:0]  op_code,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        flush,
  output logic        op_ready,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  mdu_state_e  state_q;
  logic [4:0]  cnt_q;
  logic [63:0] acc_q;
  logic [63:0] acc_d;
  logic [31:0] opnd_q;
  logic [31:0] a_q;
  logic        is_div_q;
  logic        neg_q;
  logic        rneg_q;
  logic        dz_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic        done_q;

  logic        new_signed;
  logic        new_div;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;
  logic [31:0] hi_d;
  logic [31:0] lo_d;

  // Codes 0..3 only: bit0 selects unsigned, bit1 selects divide
  assign new_signed = ~op_code[0];
  assign new_div    = op_code[1];
  assign a_mag      = mdu_abs32(op_a, new_signed);
  assign b_mag      = mdu_abs32(op_b, new_signed);

  mdu_iter_core u_core (
    .is_div_i (is_div_q),
    .acc_i    (acc_q),
    .opnd_i   (opnd_q),
    .acc_o    (acc_d)
  );

  // Divide by zero bypasses sign fixing so HI returns the raw dividend
  always_comb begin
    prod_fix = neg_q ? (~acc_q + 64'd1) : acc_q;
    quo_fix  = dz_q ? 32'hFFFF_FFFF : (neg_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0]);
    rem_fix  = dz_q ? a_q : (rneg_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32]);
    hi_d     = is_div_q ? rem_fix : prod_fix[63:32];
    lo_d     = is_div_q ? quo_fix : prod_fix[31:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= 5'd0;
      acc_q    <= 64'd0;
      opnd_q   <= 32'd0;
      a_q      <= 32'd0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      dz_q     <= 1'b0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (flush) begin
        state_q <= S_IDLE;
        cnt_q   <= 5'd0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (op_valid) begin
              case (op_code)
                MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: begin
                  acc_q    <= {32'd0, (new_div ? a_mag : b_mag)};
                  opnd_q   <= new_div ? b_mag : a_mag;
                  a_q      <= op_a;
                  is_div_q <= new_div;
                  neg_q    <= new_signed & (op_a[31] ^ op_b[31]);
                  rneg_q   <= new_signed & op_a[31];
                  dz_q     <= new_div & (op_b == 32'd0);
                  cnt_q    <= 5'd0;
                  state_q  <= S_CALC;
                end
                MDU_MTHI: begin
                  hi_q   <= op_a;
                  done_q <= 1'b1;
                end
                MDU_MTLO: begin
                  lo_q   <= op_a;
                  done_q <= 1'b1;
                end
                default: ;
              endcase
            end
          end
          S_CALC: begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + 5'd1;
            if (cnt_q == MDU_LAST_ITER) begin
              state_q <= S_FIX;
            end
          end
          S_FIX: begin
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign op_ready = (state_q == S_IDLE);
  assign busy     = ~op_ready;
  assign done     = done_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - self-checking bench for mul_div_unit
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        op_valid;
  logic [2:0]  op_code;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        flush;
  logic        op_ready;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
  } res_t;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  res_t sb_q[$];
  vec_t vecs[$];

  mul_div_unit dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .op_valid (op_valid),
    .op_code  (op_code),
    .op_a     (op_a),
    .op_b     (op_b),
    .flush    (flush),
    .op_ready (op_ready),
    .busy     (busy),
    .done     (done),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_hi, input logic [31:0] exp_lo, input bit push);
    res_t r;
    op_valid = 1'b1;
    op_code  = op;
    op_a     = a;
    op_b     = b;
    if (push) begin
      r.hi = exp_hi;
      r.lo = exp_lo;
      sb_q.push_back(r);
    end
    tick();
    op_valid = 1'b0;
    op_code  = 3'd7;
  endtask

  task automatic wait_result(input string name);
    int          cyc;
    logic [31:0] h0;
    logic [31:0] l0;
    bit          stable;
    bit          busy_ok;
    res_t        e;
    cyc = 1; h0 = hi; l0 = lo; stable = 1'b1; busy_ok = 1'b1;
    while (done !== 1'b1 && cyc < 60) begin
      if (busy !== 1'b1 || op_ready !== 1'b0) busy_ok = 1'b0;
      if (hi !== h0 || lo !== l0) stable = 1'b0;
      tick();
      cyc++;
    end
    chk({name, " latency"}, 64'(cyc), 64'd34);
    chk({name, " busy_window"}, {63'd0, busy_ok}, 64'd1);
    chk({name, " hilo_stable"}, {63'd0, stable}, 64'd1);
    chk({name, " ready_at_done"}, {63'd0, op_ready}, 64'd1);
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s scoreboard: got empty expected entry", name);
    end else begin
      e = sb_q.pop_front();
      chk({name, " hi"}, {32'd0, hi}, {32'd0, e.hi});
      chk({name, " lo"}, {32'd0, lo}, {32'd0, e.lo});
    end
  endtask

  task automatic push_vec(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] h, input logic [31:0] l);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.hi = h; v.lo = l;
    vecs.push_back(v);
  endtask

  initial begin
    logic [31:0] ra, rb, eh, el, h_prev, l_prev;
    logic [63:0] p;
    logic [2:0]  rop;
    bit          saw_done;
    int          sa, sb;

    rst_n = 1'b0; op_valid = 1'b0; flush = 1'b0; op_code = 3'd7; op_a = '0; op_b = '0;
    repeat (3) tick();
    chk("reset hi", {32'd0, hi}, 64'd0);
    chk("reset lo", {32'd0, lo}, 64'd0);
    chk("reset done", {63'd0, done}, 64'd0);
    chk("reset op_ready", {63'd0, op_ready}, 64'd1);
    chk("reset busy", {63'd0, busy}, 64'd0);
    rst_n = 1'b1;
    tick();

    push_vec(3'd0, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    push_vec(3'd1, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE);
    push_vec(3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    push_vec(3'd3, 32'd100,       32'd0,         32'h0000_0064, 32'hFFFF_FFFF);
    push_vec(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
    push_vec(3'd1, 32'd3,         32'd5,         32'h0000_0000, 32'h0000_000F);
    push_vec(3'd2, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF);
    push_vec(3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
    push_vec(3'd3, 32'hFFFF_FFFF, 32'd10,        32'h0000_0005, 32'h1999_9999);
    push_vec(3'd2, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
    push_vec(3'd0, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1);

    // Each op is issued in the done cycle of the previous one (back-to-back)
    for (int i = 0; i < vecs.size(); i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, 1'b1);
      wait_result($sformatf("vec%0d", i));
    end

    for (int i = 0; i < 6; i++) begin
      rop = 3'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      if (rop[1] && rb == 32'd0) rb = 32'd3;
      if (rop == 3'd2 && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF) rb = 32'd3;
      case (rop)
        3'd0: begin p = {{32{ra[31]}}, ra} * {{32{rb[31]}}, rb}; eh = p[63:32]; el = p[31:0]; end
        3'd1: begin p = {32'd0, ra} * {32'd0, rb}; eh = p[63:32]; el = p[31:0]; end
        3'd2: begin sa = ra; sb = rb; el = 32'(sa / sb); eh = 32'(sa % sb); end
        default: begin el = ra / rb; eh = ra % rb; end
      endcase
      issue(rop, ra, rb, eh, el, 1'b1);
      wait_result($sformatf("rnd%0d", i));
    end

    tick();
    op_valid = 1'b1; op_code = 3'd4; op_a = 32'h1234_5678;
    tick();
    chk("mthi hi", {32'd0, hi}, {32'd0, 32'h1234_5678});
    chk("mthi done", {63'd0, done}, 64'd1);
    chk("mthi ready", {63'd0, op_ready}, 64'd1);
    op_code = 3'd5; op_a = 32'h9ABC_DEF0;
    tick();
    chk("mtlo lo", {32'd0, lo}, {32'd0, 32'h9ABC_DEF0});
    chk("mtlo hi kept", {32'd0, hi}, {32'd0, 32'h1234_5678});
    chk("mtlo done", {63'd0, done}, 64'd1);
    chk("mtlo ready", {63'd0, op_ready}, 64'd1);
    op_code = 3'd6;
    tick();
    chk("nop after mt done", {63'd0, done}, 64'd0);
    op_valid = 1'b0;
    tick();
    chk("nop done", {63'd0, done}, 64'd0);
    chk("nop hilo", {hi, lo}, {32'h1234_5678, 32'h9ABC_DEF0});

    op_valid = 1'b1; op_code = 3'd4; op_a = 32'hDEAD_BEEF; flush = 1'b1;
    tick();
    chk("idle flush mthi blocked", {32'd0, hi}, {32'd0, 32'h1234_5678});
    chk("idle flush no done", {63'd0, done}, 64'd0);
    op_code = 3'd0; op_a = 32'd7; op_b = 32'd9;
    tick();
    flush = 1'b0; op_valid = 1'b0;
    chk("idle flush mult blocked", {63'd0, op_ready}, 64'd1);

    h_prev = hi; l_prev = lo;
    issue(3'd0, 32'd7, 32'd9, 32'd0, 32'd0, 1'b0);
    chk("flush pre busy", {63'd0, busy}, 64'd1);
    repeat (8) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush ready", {63'd0, op_ready}, 64'd1);
    chk("flush busy", {63'd0, busy}, 64'd0);
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) saw_done = 1'b1;
      tick();
    end
    chk("flush no done", {63'd0, saw_done}, 64'd0);
    chk("flush hilo kept", {hi, lo}, {h_prev, l_prev});

    issue(3'd2, 32'd100, 32'd7, 32'd0, 32'd0, 1'b0);
    repeat (19) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("async rst hi", {32'd0, hi}, 64'd0);
    chk("async rst lo", {32'd0, lo}, 64'd0);
    chk("async rst done", {63'd0, done}, 64'd0);
    chk("async rst ready", {63'd0, op_ready}, 64'd1);
    chk("async rst busy", {63'd0, busy}, 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    issue(3'd1, 32'd3, 32'd5, 32'd0, 32'd15, 1'b1);
    wait_result("post_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
